write_back: RTL

- Final pipeline stage, directly downstream of the memory-access stage.
- Consumes the forwarded instruction word and result, and decodes the opcode to decide whether rd is written.
- Owns the integer register file: two read ports for decode, plus a registered forwarding path.
- Tracks retired instructions and halts the core on ECALL/EBREAK through a small run/halt state machine.

---
 rtl/write_back.sv | 105 ++++++++++
 1 files changed

// File: rtl/write_back.sv
// write_back: final pipeline stage; owns the integer register file, forwards committed writes,
// counts retired instructions and halts the core on ECALL/EBREAK.
// Ports:
//   clk, rst_n                  clock and synchronous active-low reset
//   instruction_in, wb_data_in  instruction word (0 = bubble) and its result from the memory stage
//   resume                      leave the HALTED state
//   rs1_addr/rs1_data           combinational read port A, with write-through bypass
//   rs2_addr/rs2_data           combinational read port B, with write-through bypass
//   fwd_valid/fwd_rd/fwd_data   registered copy of the write committed last cycle
//   halt                        core halted
//   retired                     retired non-bubble instruction count
// Optional feature macro: WB_LOAD_SIGNEXT_EN re-extends LOAD results from funct3.
module write_back #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  instruction_in,
  input  logic [XLEN-1:0]  wb_data_in,
  input  logic             resume,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic             halt,
  output logic [CNT_W-1:0] retired
);
  localparam logic RUN = 1'b0;
  localparam logic HALTED = 1'b1;
  localparam logic [6:0] OP_OP = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  logic             state;
  logic [XLEN-1:0]  regs [NREGS];
  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic [2:0]       funct3;
  logic [11:0]      imm;
  logic             run;
  logic             writes_rd;
  logic             we;
  logic             retire;
  logic             halt_now;
  logic [XLEN-1:0]  wdata;
  logic             unused;
  assign opcode = instruction_in[6:0];
  assign rd = instruction_in[11:7];
  assign funct3 = instruction_in[14:12];
  assign imm = instruction_in[31:20];
  assign unused = ^instruction_in[19:15];
  assign run = state == RUN;
  assign halt = state == HALTED;
  assign writes_rd = opcode == OP_OP || opcode == OP_IMM || opcode == OP_LUI || opcode == OP_AUIPC ||
                     opcode == OP_LOAD || opcode == OP_JAL || opcode == OP_JALR;
  assign we = run && writes_rd && rd != 5'd0;
  assign retire = run && instruction_in != '0;
  // Only ECALL (imm 0) and EBREAK (imm 1) halt; CSR ops share the opcode but have funct3 != 0.
  assign halt_now = run && opcode == OP_SYSTEM && funct3 == 3'd0 && (imm == 12'd0 || imm == 12'd1);
`ifdef WB_LOAD_SIGNEXT_EN
  assign wdata = opcode != OP_LOAD ? wb_data_in :
                 funct3 == 3'd0 ? {{(XLEN-8){wb_data_in[7]}}, wb_data_in[7:0]} :
                 funct3 == 3'd1 ? {{(XLEN-16){wb_data_in[15]}}, wb_data_in[15:0]} :
                 funct3 == 3'd4 ? {{(XLEN-8){1'b0}}, wb_data_in[7:0]} :
                 funct3 == 3'd5 ? {{(XLEN-16){1'b0}}, wb_data_in[15:0]} : wb_data_in;
`else
  assign wdata = wb_data_in;
`endif
  // A write landing this cycle is visible to decode immediately; x0 always reads zero.
  assign rs1_data = rs1_addr == 5'd0 ? '0 : (we && rd == rs1_addr) ? wdata : regs[rs1_addr];
  assign rs2_data = rs2_addr == 5'd0 ? '0 : (we && rd == rs2_addr) ? wdata : regs[rs2_addr];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[rd] <= wdata;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      retired <= '0;
      fwd_valid <= 1'b0;
      fwd_rd <= 5'd0;
      fwd_data <= '0;
    end else begin
      state <= halt_now ? HALTED : (halt && resume) ? RUN : state;
      retired <= retire ? retired + 1'b1 : retired;
      fwd_valid <= we;
      if (we) begin
        fwd_rd <= rd;
        fwd_data <= wdata;
      end
    end
  end
endmodule
